// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider (DIV/DIVU) with valid/ready handshakes and flush cancel
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cancel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t             state, state_next;
  logic [2*WIDTH-1:0] a, a_next;
  logic [WIDTH-1:0]   ym, xmag, ymag, q, rem;
  logic [WIDTH:0]     diff;
  logic [CW-1:0]      cnt;
  logic               neg_s, neg_r, y_zero, accept, last;

  assign in_ready  = state == IDLE && !reset;
  assign out_valid = state == DONE;
  assign accept    = in_valid && in_ready && !cancel;
  assign last      = state == BUSY && cnt == CW'(WIDTH - 1);
  assign xmag      = (x[WIDTH-1] && div_signed) ? -x : x;
  assign ymag      = (y[WIDTH-1] && div_signed) ? -y : y;
  // trial subtract uses the bit shifted out of A so partial remainders up to 2*|y| fit
  assign diff      = a[2*WIDTH-1:WIDTH-1] - {1'b0, ym};
  assign a_next    = diff[WIDTH] ? {a[2*WIDTH-2:0], 1'b0} : {diff[WIDTH-1:0], a[WIDTH-2:0], 1'b1};
  assign q         = a_next[WIDTH-1:0];
  assign rem       = a_next[2*WIDTH-1:WIDTH];

  always_comb begin
    state_next = cancel ? IDLE :
                 accept ? BUSY :
                 last ? DONE :
                 (state == DONE && out_ready) ? IDLE : state;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a      <= '0;
      ym     <= '0;
      cnt    <= '0;
      neg_s  <= 1'b0;
      neg_r  <= 1'b0;
      y_zero <= 1'b0;
      s      <= '0;
      r      <= '0;
    end else begin
      if (accept) begin
        a      <= {{WIDTH{1'b0}}, xmag};
        ym     <= ymag;
        cnt    <= '0;
        neg_s  <= div_signed && (x[WIDTH-1] ^ y[WIDTH-1]);
        neg_r  <= div_signed && x[WIDTH-1];
        y_zero <= y == '0;
      end else if (state == BUSY && !cancel) begin
        a   <= a_next;
        cnt <= cnt + 1'b1;
      end
      // a zero divisor yields |x| as remainder, so only the quotient needs forcing
      if (last && !cancel) begin
        s <= y_zero ? '1 : neg_s ? -q : q;
        r <= neg_r ? -rem : rem;
      end
    end
  end
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: randomized self-checking bench for div_iter against an arithmetic reference model
module tb_div_iter;
  logic        clk = 0, reset = 1, cancel = 0, in_valid = 0, div_signed = 0, out_ready = 0;
  logic [31:0] x = 0, y = 0, s, r;
  logic        in_ready, out_valid;
  int          checks = 0, errors = 0;

  div_iter #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .cancel(cancel), .in_valid(in_valid), .in_ready(in_ready),
    .div_signed(div_signed), .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .r(r)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] qq, mm;
    if (b == 0) begin qq = '1; mm = a; end
    else if (!sgn) begin qq = a / b; mm = a % b; end
    else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin qq = a; mm = 0; end
    else begin qq = $signed(a) / $signed(b); mm = $signed(a) % $signed(b); end
    return {qq, mm};
  endfunction

  task automatic do_op(input logic sgn, input logic [31:0] xv, input logic [31:0] yv, input int stall);
    logic [63:0] e;
    logic [31:0] s0, r0;
    int n;
    e = ref_div(sgn, xv, yv);
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 1);
    div_signed = sgn; x = xv; y = yv; in_valid = 1; out_ready = (stall == 0);
    n = 0;
    do begin
      @(negedge clk);
      in_valid = 0; x = $urandom; y = $urandom; div_signed = ~sgn;
      n++;
    end while (!out_valid && n < 100);
    check("latency", 32'(n), 33);
    check("quotient", s, e[63:32]);
    check("remainder", r, e[31:0]);
    if (stall > 0) begin
      s0 = s; r0 = r;
      repeat (stall) begin
        @(negedge clk);
        check("stall_valid", 32'(out_valid), 1);
        check("stall_ready", 32'(in_ready), 0);
        check("stall_s", s, s0);
        check("stall_r", r, r0);
      end
      out_ready = 1;
    end
    @(negedge clk);
    out_ready = 0;
    check("handoff_in_ready", 32'(in_ready), 1);
    check("handoff_out_valid", 32'(out_valid), 0);
    check("hold_s", s, e[63:32]);
  endtask

  task automatic start_op(input logic sgn, input logic [31:0] xv, input logic [31:0] yv);
    @(negedge clk);
    div_signed = sgn; x = xv; y = yv; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
  endtask

  initial begin
    int bad;
    logic [31:0] xr, yr;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_s", s, 0);
    check("rst_r", r, 0);
    reset = 0;
    out_ready = 1;
    do_op(0, 100, 7, 0);
    do_op(1, -32'sd7, 2, 0);
    do_op(1, 7, -32'sd2, 0);
    do_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(0, 32'h1234_5678, 0, 0);
    do_op(1, 32'h1234_5678, 0, 0);
    do_op(1, 32'h8765_4321, 0, 0);
    // flush mid-operation
    start_op(0, 1000, 3);
    repeat (9) @(negedge clk);
    cancel = 1;
    @(negedge clk);
    cancel = 0;
    check("cancel_in_ready", 32'(in_ready), 1);
    bad = 0;
    repeat (40) begin @(negedge clk); if (out_valid) bad++; end
    check("cancel_no_result", 32'(bad), 0);
    do_op(0, 9, 3, 0);
    @(negedge clk);
    cancel = 1; in_valid = 1; x = 50; y = 5;
    @(negedge clk);
    cancel = 0; in_valid = 0;
    check("cancel_idle_no_accept", 32'(in_ready), 1);
    bad = 0;
    repeat (40) begin @(negedge clk); if (out_valid) bad++; end
    check("cancel_idle_no_result", 32'(bad), 0);
    do_op(1, -32'sd1000, 33, 5);
    // reset in the middle of BUSY
    start_op(0, 77, 5);
    repeat (19) @(negedge clk);
    reset = 1;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 0);
    reset = 0;
    check("midrst_s", s, 0);
    check("midrst_r", r, 0);
    @(negedge clk);
    check("midrst_ready", 32'(in_ready), 1);
    bad = 0;
    repeat (40) begin @(negedge clk); if (out_valid) bad++; end
    check("midrst_no_result", 32'(bad), 0);
    for (int i = 0; i < 30; i++) begin
      xr = $urandom;
      yr = (i % 3 == 0) ? ($urandom >> $urandom_range(31, 0)) : $urandom;
      if (i % 7 == 0) xr = 32'h8000_0000;
      do_op(1'($urandom_range(1, 0)), xr, yr, (i % 5 == 0) ? 2 : 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
